// File: rtl/alu_defs.sv
// Shared definitions for the lab ALU datapath.
// Holds the sequential multiplier FSM state encoding and the default operand width.
package alu_defs;

  localparam int unsigned WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mult_16bit_if.sv
// Request/result bundle for the sequential multiplier.
// Ports:
//   start  : request, sampled only when the multiplier is idle
//   A, B   : multiplicand / multiplier, captured on an accepted start
//   busy   : high while an operation is running or completing
//   done   : one-cycle completion pulse
//   P_lo   : registered product bits [WIDTH-1:0]
//   P_hi   : registered product bits [2*WIDTH-1:WIDTH]
//   zero   : registered, high when the full product is 0
interface seq_mult_16bit_if #(
  parameter int unsigned WIDTH = alu_defs::WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] P_lo;
  logic [WIDTH-1:0] P_hi;
  logic             zero;

  modport master (
    output start, A, B,
    input  busy, done, P_lo, P_hi, zero
  );

  modport slave (
    input  start, A, B,
    output busy, done, P_lo, P_hi, zero
  );

endinterface

// File: rtl/seq_mult_ctrl.sv
// Sequencer for the shift-add multiplier: FSM plus iteration counter.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start_i      : request, honoured only in IDLE
//   load_c_o     : combinational strobe, capture operands this edge
//   step_c_o     : combinational strobe, perform one shift-add iteration
//   finish_c_o   : combinational strobe, last iteration; latch the product
//   busy_o       : registered, high in RUN and DONE
//   done_o       : registered, high for the single DONE cycle
module seq_mult_ctrl
  import alu_defs::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic load_c_o,
  output logic step_c_o,
  output logic finish_c_o,
  output logic busy_o,
  output logic done_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // State, counter and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state, counter update and datapath strobes
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    load_c_o   = 1'b0;
    step_c_o   = 1'b0;
    finish_c_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          load_c_o = 1'b1;
          count_d  = CW'(WIDTH);
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        step_c_o = 1'b1;
        count_d  = count_q - CW'(1);
        // count==1 means this edge performs the final iteration
        if (count_q == CW'(1)) begin
          finish_c_o = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Flags are decodes of the next state, so they register alongside it
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/seq_mult_16bit.sv
// Multi-cycle unsigned shift-add multiplier (WIDTH x WIDTH -> 2*WIDTH).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of seq_mult_16bit_if (start/A/B in; busy/done/P_lo/P_hi/zero out)
// The product halves are held in registers and only change when an operation
// completes or on reset, so downstream muxing sees stable operands.
module seq_mult_16bit
  import alu_defs::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  seq_mult_16bit_if.slave bus
);

  logic             load_c, step_c, finish_c;
  logic             busy, done;

  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] p_lo_q, p_lo_d;
  logic [WIDTH-1:0] p_hi_q, p_hi_d;
  logic             zero_q, zero_d;
  logic [WIDTH:0]   sum_c;

  seq_mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .start_i    (bus.start),
    .load_c_o   (load_c),
    .step_c_o   (step_c),
    .finish_c_o (finish_c),
    .busy_o     (busy),
    .done_o     (done)
  );

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      p_lo_q   <= '0;
      p_hi_q   <= '0;
      zero_q   <= 1'b1;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      p_lo_q   <= p_lo_d;
      p_hi_q   <= p_hi_d;
      zero_q   <= zero_d;
    end
  end

  // Shift-add iteration and result capture
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    p_lo_d   = p_lo_q;
    p_hi_d   = p_hi_q;
    zero_d   = zero_q;
    // acc carries one extra bit so the add's carry-out is never lost
    sum_c    = mplier_q[0] ? (acc_q + {1'b0, mcand_q}) : acc_q;
    if (load_c) begin
      mcand_d  = bus.A;
      mplier_d = bus.B;
      acc_d    = '0;
    end else if (step_c) begin
      // {sum, mplier} >> 1: low product bits shift into the multiplier register
      acc_d    = {1'b0, sum_c[WIDTH:1]};
      mplier_d = {sum_c[0], mplier_q[WIDTH-1:1]};
    end
    if (finish_c) begin
      p_hi_d = acc_d[WIDTH-1:0];
      p_lo_d = mplier_d;
      zero_d = ({acc_d[WIDTH-1:0], mplier_d} == '0);
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.P_lo = p_lo_q;
  assign bus.P_hi = p_hi_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_seq_mult_16bit.sv
// Scoreboard bench for seq_mult_16bit: the driver pushes a*b per accepted
// request, a negedge monitor pops on every done pulse and otherwise checks
// that the product registers hold their last value.
module tb_seq_mult_16bit;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_mult_16bit_if #(.WIDTH(W)) bus ();

  seq_mult_16bit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors  = 0;
  int errors   = 0;
  int done_cnt = 0;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_p    = '0;
  logic           last_zero = 1'b1;
  logic [2*W-1:0] mon_e;
  bit             mon_en    = 1'b0;
  bit             rst_edge  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    vectors++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Remember whether the last active edge was a reset edge
  always @(posedge clk) rst_edge = rst;

  // Monitor: compare on done, otherwise verify the outputs are held
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_edge) begin
        last_p    = '0;
        last_zero = 1'b1;
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("product", {bus.P_hi, bus.P_lo}, mon_e);
          check("zero", 32'(bus.zero), 32'(mon_e == '0));
          last_p    = mon_e;
          last_zero = (mon_e == '0);
        end
      end else begin
        check("hold_p", {bus.P_hi, bus.P_lo}, last_p);
        check("hold_zero", 32'(bus.zero), 32'(last_zero));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    if (bus.busy !== 1'b0) fail_timeout("wait_idle");
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < 100) begin
      tick();
      n++;
    end
    if (done_cnt == d0) fail_timeout("wait_done");
  endtask

  // Issue one request from IDLE; returns in cycle 1 of the run
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    wait_idle();
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    exp_q.push_back(32'(a) * 32'(b));
    tick();
    bus.start = 1'b0;
    bus.A     = 16'($urandom);
    bus.B     = 16'($urandom);
  endtask

  initial begin
    int d0;
    int n;
    int gap;
    logic [W-1:0] ra, rb;

    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    rst       = 1'b1;
    repeat (2) tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_p", {bus.P_hi, bus.P_lo}, 32'd0);
    check("rst_zero", 32'(bus.zero), 32'd1);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Latency and busy window: 40*33
    issue(16'd40, 16'd33);
    for (int c = 1; c <= 18; c++) begin
      check("busy_cycle", 32'(bus.busy), 32'(c <= 17));
      check("done_cycle", 32'(bus.done), 32'(c == 17));
      tick();
    end

    // Carry through the accumulator, then zero products
    issue(16'hFFFF, 16'hFFFF);
    wait_done();
    issue(16'h1234, 16'h0000);
    wait_done();
    issue(16'h0000, 16'hABCD);
    wait_done();

    // Start while busy is ignored
    d0 = done_cnt;
    issue(16'd3, 16'd5);
    repeat (4) tick();
    bus.A     = 16'd7;
    bus.B     = 16'd9;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.A     = 16'($urandom);
    bus.B     = 16'($urandom);
    wait_done();
    repeat (20) tick();
    check("single_done", 32'(done_cnt - d0), 32'd1);

    // Reset mid-operation abandons the run
    wait_idle();
    d0        = done_cnt;
    bus.A     = 16'd100;
    bus.B     = 16'd200;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_p", {bus.P_hi, bus.P_lo}, 32'd0);
    check("midrst_zero", 32'(bus.zero), 32'd1);
    repeat (25) tick();
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    issue(16'd100, 16'd200);
    wait_done();

    // Back-to-back with start held high
    wait_idle();
    d0        = done_cnt;
    bus.A     = 16'd2;
    bus.B     = 16'd3;
    bus.start = 1'b1;
    exp_q.push_back(32'd6);
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (bus.done !== 1'b1) fail_timeout("b2b_first_done");
    bus.A = 16'd4;
    bus.B = 16'd5;
    exp_q.push_back(32'd20);
    tick();
    gap = 1;
    while (bus.done !== 1'b1 && gap < 100) begin
      tick();
      gap++;
    end
    bus.start = 1'b0;
    check("b2b_gap", 32'(gap), 32'd18);
    repeat (3) tick();
    check("b2b_done_count", 32'(done_cnt - d0), 32'd2);

    // Randomized operands
    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom);
      rb = (i % 5 == 0) ? 16'd0 : 16'($urandom);
      issue(ra, rb);
      if (i % 2 == 0) wait_done();
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) fail_timeout("drain");
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult_16bit.md
Name: seq_mult_16bit

Overview:
Multi-cycle unsigned shift-add multiplier for the lab ALU datapath.
- Takes two 16-bit operands and produces a 32-bit product after a fixed number of cycles.
- Product halves P_lo/P_hi are held stable in registers and feed the operand inputs of the 16-bit 2:1 result mux downstream.
- The mux sel chooses which half, or the multiplier versus another ALU result, is forwarded.

Parameters:
WIDTH, 16, operand width in bits; product is 2*WIDTH bits; iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
start  input  1  request; sampled only in IDLE.
A  input  WIDTH  multiplicand; captured on accepted start.
B  input  WIDTH  multiplier; captured on accepted start.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse in DONE.
P_lo  output  WIDTH  product bits [WIDTH-1:0], registered.
P_hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH], registered.
zero  output  1  registered; high when the full 2*WIDTH product is 0.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, P_lo=0, P_hi=0, zero=1, internal acc/mcand/mplier/count=0.
- Reset mid-operation: the in-flight operation is abandoned at the next edge, with no done pulse. Reset dominates start.
- States: IDLE, RUN, DONE.
- IDLE -> RUN:
  - Occurs at an edge where start=1.
  - Latch mcand=A and mplier=B.
  - Clear acc (WIDTH+1 bits, including carry).
  - Set count=WIDTH.
- RUN, each cycle:
  - If mplier[0]=1, sum = acc + mcand (WIDTH+1 bits); otherwise sum = acc.
  - Shift {sum, mplier} right by 1: the new mplier MSB takes sum[0], and acc takes sum[WIDTH:1].
  - Decrement count.
  - When count reaches 1 at the edge, leave RUN.
- RUN -> DONE:
  - The final iteration completes at the transition edge.
  - Load {P_hi,P_lo} = final {acc[WIDTH-1:0], mplier} and zero = (product==0).
- DONE -> IDLE: unconditional after one cycle.
- Latency: start accepted at edge k; done=1 for exactly the cycle between edges k+WIDTH and k+WIDTH+1 (cycle 17 for WIDTH=16). P_lo/P_hi are valid in that same cycle.
- Output hold: P_lo, P_hi and zero change only at the RUN->DONE edge or on reset. They hold the last result indefinitely, including through a later RUN.
- start while busy (RUN or DONE): ignored, with no effect on operands or count. A new start is accepted from the IDLE cycle after DONE, so the minimum period between accepted starts is WIDTH+2 cycles.
- A/B changing during RUN: no effect, because operands are captured.
- Arithmetic:
  - Unsigned only.
  - The full 2*WIDTH product is produced, so overflow is impossible.
  - The carry out of each add is retained through the WIDTH+1-bit acc.
- done and busy are registered-state decodes, not combinational from start.

Decomposition:
- Shared package (alu_defs): state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
- One natural sub-module, seq_mult_ctrl: holds the FSM and the iteration counter, and emits load/step/finish strobes. The shift-add datapath stays in seq_mult_16bit.

Test Plan:
- Reset then start with A=40, B=33 -> done at cycle 17 after the accepted start; P_lo=16'h0528, P_hi=16'h0000, zero=0; busy high from cycle 1 to cycle 17 inclusive.
- A=16'hFFFF, B=16'hFFFF -> P_hi=16'hFFFE, P_lo=16'h0001; exercises the carry into acc.
- A=16'h1234, B=0 -> P_hi=P_lo=0, zero=1; also check A=0, B=16'hABCD gives the same.
- Start A=3, B=5; at cycle 5 pulse start with A=7, B=9 and change A/B -> result is 15 (16'h000F), and exactly one done pulse occurs.
- Start A=100, B=200; assert rst at cycle 8 for one cycle -> busy=0, done never pulses, P_lo=P_hi=0, zero=1. A following start with A=100, B=200 gives P_lo=16'h4E20.
- Back-to-back: hold start high continuously with A=2, B=3, then A=4, B=5 after the first done -> second start is accepted in the IDLE cycle after DONE. P updates first to 6, then 20, and zero stays 0 throughout.
